// File: rtl/mips32_pkg.sv
// Shared MIPS32 decode definitions: opcodes, instruction field positions,
// the ID/EX register layout and operand-usage helpers for decode and execute.
package mips32_pkg;

   localparam int DATA_W = 32;
   localparam int REG_N  = 32;
   localparam int REG_AW = 5;

   localparam logic [DATA_W-1:0] NOP_IR = 32'h0000_0000;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [5:0] {
      OP_ADD   = 6'h00, OP_SUB  = 6'h01, OP_MUL  = 6'h02,
      OP_SLT   = 6'h03, OP_OR   = 6'h04, OP_AND  = 6'h05,
      OP_ADDI  = 6'h10, OP_SUBI = 6'h11, OP_MULI = 6'h12,
      OP_SLTI  = 6'h13, OP_ORI  = 6'h14, OP_ANDI = 6'h15,
      OP_LW    = 6'h20, OP_SW   = 6'h21,
      OP_BEQZ  = 6'h34, OP_BNEQZ = 6'h35,
      OP_HLT   = 6'h3F
   } opcode_e;

   typedef struct packed {
      logic [DATA_W-1:0] ir;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] npc;
      logic              valid;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{ir: NOP_IR, a: '0, b: '0, imm: '0, npc: '0, valid: 1'b0};

   // Only function codes 0..5 are real ALU ops; the rest of the space decodes as NOP.
   function automatic logic is_alu(input logic [5:0] op);
      return !op[5] && (op[3:0] <= 4'd5);
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return op == OP_LW;
   endfunction

   function automatic logic is_halt(input logic [5:0] op);
      return op == OP_HLT;
   endfunction

   function automatic logic reads_rs(input logic [5:0] op);
      return is_alu(op) || op == OP_LW || op == OP_SW || op == OP_BEQZ || op == OP_BNEQZ;
   endfunction

   function automatic logic reads_rt(input logic [5:0] op);
      return (is_alu(op) && !op[4]) || op == OP_SW;
   endfunction

   function automatic logic [REG_AW-1:0] dest_reg(input logic [5:0] op,
                                                  input logic [REG_AW-1:0] rt,
                                                  input logic [REG_AW-1:0] rd);
      if (is_alu(op) && !op[4])      return rd;
      else if (is_alu(op) || is_load(op)) return rt;
      else                           return '0;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, r0 hardwired to zero, synchronous active-low clear.
module regfile
   import mips32_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic              wr_hit;

   assign wr_hit = we && (waddr != '0);

   // NOTE: start every always_comb from a full default so no path leaves a latch.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) regs_d[waddr] = wdata;
   end

   // NOTE: sequential state uses <= so all flops sample the same pre-edge values.
   // NOTE: this array is reset on purpose; a cleared register file is architectural state here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = (raddr_a == '0)                ? '0    :
                    (wr_hit && waddr == raddr_a)  ? wdata : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0)                ? '0    :
                    (wr_hit && waddr == raddr_b)  ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/id_stage.sv
// MIPS32 instruction-decode stage: register-file read, load-use hazard stall,
// bubble insertion on stall/flush/halt, and the ID/EX pipeline register.
module id_stage
   import mips32_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] IR_if,
   input  logic [DATA_W-1:0] NPC_if,
   input  logic              valid_if,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] Imm,
   output logic [DATA_W-1:0] NPC_id,
   output logic [DATA_W-1:0] IR_id,
   output logic              valid_id,
   output logic              stall,
   output logic              halted
);

   idex_t idex_q, idex_d;
   logic  halted_q, halted_d;

   logic [5:0]        op_if, op_id;
   logic [REG_AW-1:0] rs_if, rt_if, rt_id;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic              load_use;

   assign op_if = IR_if[OPC_HI:OPC_LO];
   assign rs_if = IR_if[RS_HI:RS_LO];
   assign rt_if = IR_if[RT_HI:RT_LO];
   assign op_id = idex_q.ir[OPC_HI:OPC_LO];
   assign rt_id = idex_q.ir[RT_HI:RT_LO];

   regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (rs_if),
      .rdata_a (rs_val),
      .raddr_b (rt_if),
      .rdata_b (rt_val),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   always_comb begin
      load_use = idex_q.valid && is_load(op_id) && (rt_id != '0) &&
                 valid_if && !halted_q &&
                 ((reads_rs(op_if) && rs_if == rt_id) ||
                  (reads_rt(op_if) && rt_if == rt_id));
   end

   // A taken branch kills the decode slot, so it also cancels any stall request.
   assign stall = load_use && !flush;

   always_comb begin
      idex_d   = IDEX_BUBBLE;
      halted_d = halted_q;
      if (!flush && !halted_q && !load_use && valid_if) begin
         idex_d.ir    = IR_if;
         idex_d.a     = reads_rs(op_if) ? rs_val : '0;
         idex_d.b     = reads_rt(op_if) ? rt_val : '0;
         idex_d.imm   = {{16{IR_if[IMM_HI]}}, IR_if[IMM_HI:IMM_LO]};
         idex_d.npc   = NPC_if;
         idex_d.valid = 1'b1;
         if (is_halt(op_if)) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_q   <= IDEX_BUBBLE;
         halted_q <= 1'b0;
      end else begin
         idex_q   <= idex_d;
         halted_q <= halted_d;
      end
   end

   assign A        = idex_q.a;
   assign B        = idex_q.b;
   assign Imm      = idex_q.imm;
   assign NPC_id   = idex_q.npc;
   assign IR_id    = idex_q.ir;
   assign valid_id = idex_q.valid;
   assign halted   = halted_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, bypass, load-use stall,
// flush, halt and reset behaviour with hand-computed expectations.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ir_if, npc_if;
   logic        valid_if, flush, wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] a, b, imm, npc_id, ir_id;
   logic        valid_id, stall, halted;

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-encoded instructions: {op,rs,rt,rd/imm}
   localparam logic [31:0] ADDI_R1_R0_M3 = 32'h4001_FFFD; // op10 rs0 rt1 imm FFFD
   localparam logic [31:0] ADD_R6_R5_R5  = 32'h00A5_3000;
   localparam logic [31:0] ADD_R7_R5_R5  = 32'h00A5_3800;
   localparam logic [31:0] ADD_R8_R0_R0  = 32'h0000_4000;
   localparam logic [31:0] LW_R2_0_R1    = 32'h8022_0000; // op20 rs1 rt2
   localparam logic [31:0] LW_R0_0_R1    = 32'h8020_0000;
   localparam logic [31:0] LW_R9_0_R1    = 32'h8029_0000;
   localparam logic [31:0] ADD_R3_R2_R4  = 32'h0044_1800; // rs2 rt4 rd3
   localparam logic [31:0] ADD_R3_R0_R4  = 32'h0004_1800;
   localparam logic [31:0] SW_R2_4_R1    = 32'h8422_0004; // op21 rs1 rt2
   localparam logic [31:0] SUB_R3_R2_R4  = 32'h0444_1800;
   localparam logic [31:0] HLT           = 32'hFC00_0000;

   id_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .IR_if    (ir_if),
      .NPC_if   (npc_if),
      .valid_if (valid_if),
      .flush    (flush),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .A        (a),
      .B        (b),
      .Imm      (imm),
      .NPC_id   (npc_id),
      .IR_id    (ir_id),
      .valid_id (valid_id),
      .stall    (stall),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      n_checks++; if (ir_id !== 32'h0)    begin n_fail++; $display("FAIL %s_ir_id: got %h want %h", tag, ir_id, 32'h0); end
      n_checks++; if (a !== 32'h0)        begin n_fail++; $display("FAIL %s_A: got %h want %h", tag, a, 32'h0); end
      n_checks++; if (b !== 32'h0)        begin n_fail++; $display("FAIL %s_B: got %h want %h", tag, b, 32'h0); end
      n_checks++; if (imm !== 32'h0)      begin n_fail++; $display("FAIL %s_imm: got %h want %h", tag, imm, 32'h0); end
      n_checks++; if (npc_id !== 32'h0)   begin n_fail++; $display("FAIL %s_npc: got %h want %h", tag, npc_id, 32'h0); end
      n_checks++; if (valid_id !== 1'b0)  begin n_fail++; $display("FAIL %s_valid: got %b want 0", tag, valid_id); end
      n_checks++; if (halted !== 1'b0)    begin n_fail++; $display("FAIL %s_halted: got %b want 0", tag, halted); end
      n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL %s_stall: got %b want 0", tag, stall); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_if = 1'b0; flush = 1'b0; wb_en = 1'b0;
      wb_addr = 5'd0; wb_data = 32'h0; ir_if = 32'h0; npc_if = 32'h0;
      step(); step();
      check_reset_values("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_decode_imm();
      ir_if = ADDI_R1_R0_M3; npc_if = 32'h0000_0104; valid_if = 1'b1;
      step();
      n_checks++; if (imm !== 32'hFFFF_FFFD)  begin n_fail++; $display("FAIL addi_imm: got %h want %h", imm, 32'hFFFF_FFFD); end
      n_checks++; if (a !== 32'h0)            begin n_fail++; $display("FAIL addi_A: got %h want %h", a, 32'h0); end
      n_checks++; if (valid_id !== 1'b1)      begin n_fail++; $display("FAIL addi_valid: got %b want 1", valid_id); end
      n_checks++; if (ir_id !== ADDI_R1_R0_M3) begin n_fail++; $display("FAIL addi_ir: got %h want %h", ir_id, ADDI_R1_R0_M3); end
      n_checks++; if (npc_id !== 32'h0000_0104) begin n_fail++; $display("FAIL addi_npc: got %h want %h", npc_id, 32'h104); end
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234; ir_if = ADD_R6_R5_R5;
      step();
      n_checks++; if (a !== 32'h1234) begin n_fail++; $display("FAIL bypass_A: got %h want %h", a, 32'h1234); end
      n_checks++; if (b !== 32'h1234) begin n_fail++; $display("FAIL bypass_B: got %h want %h", b, 32'h1234); end
      wb_en = 1'b0; ir_if = ADD_R7_R5_R5;
      step();
      n_checks++; if (a !== 32'h1234) begin n_fail++; $display("FAIL stored_A: got %h want %h", a, 32'h1234); end
      n_checks++; if (ir_id !== ADD_R7_R5_R5) begin n_fail++; $display("FAIL stored_ir: got %h want %h", ir_id, ADD_R7_R5_R5); end
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF; ir_if = ADD_R8_R0_R0;
      step();
      n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL r0_bypass_A: got %h want %h", a, 32'h0); end
      wb_en = 1'b0;
      step();
      n_checks++; if (b !== 32'h0) begin n_fail++; $display("FAIL r0_stored_B: got %h want %h", b, 32'h0); end
   endtask

   task automatic test_load_use();
      valid_if = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0100;
      step();
      wb_addr = 5'd4; wb_data = 32'h0000_0007;
      step();
      wb_en = 1'b0; valid_if = 1'b1; ir_if = LW_R2_0_R1; npc_if = 32'h0000_0200;
      step();
      n_checks++; if (a !== 32'h100) begin n_fail++; $display("FAIL lw_A: got %h want %h", a, 32'h100); end
      ir_if = ADD_R3_R2_R4; npc_if = 32'h0000_0204;
      settle();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
      step();
      n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b want 0", valid_id); end
      n_checks++; if (ir_id !== 32'h0)   begin n_fail++; $display("FAIL lu_bubble_ir: got %h want %h", ir_id, 32'h0); end
      n_checks++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", stall); end
      step();
      n_checks++; if (ir_id !== ADD_R3_R2_R4) begin n_fail++; $display("FAIL lu_add_ir: got %h want %h", ir_id, ADD_R3_R2_R4); end
      n_checks++; if (b !== 32'h7)            begin n_fail++; $display("FAIL lu_add_B: got %h want %h", b, 32'h7); end
      n_checks++; if (npc_id !== 32'h204)     begin n_fail++; $display("FAIL lu_add_npc: got %h want %h", npc_id, 32'h204); end
      // LW r0 never creates a hazard
      ir_if = LW_R0_0_R1;
      step();
      ir_if = ADD_R3_R0_R4;
      settle();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_r0_stall: got %b want 0", stall); end
      // unrelated rt
      ir_if = LW_R9_0_R1;
      step();
      ir_if = ADD_R3_R2_R4;
      settle();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_unrel_stall: got %b want 0", stall); end
      // store data (rt) dependency
      ir_if = LW_R2_0_R1;
      step();
      ir_if = SW_R2_4_R1;
      settle();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_rt_stall: got %b want 1", stall); end
      valid_if = 1'b0;
      settle();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL invalid_if_stall: got %b want 0", stall); end
      step();
   endtask

   task automatic test_flush();
      valid_if = 1'b1; ir_if = LW_R2_0_R1;
      step();
      ir_if = SUB_R3_R2_R4; flush = 1'b1;
      settle();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
      step();
      n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", valid_id); end
      n_checks++; if (ir_id !== 32'h0)   begin n_fail++; $display("FAIL flush_ir: got %h want %h", ir_id, 32'h0); end
      flush = 1'b0;
      step();
      n_checks++; if (ir_id !== SUB_R3_R2_R4) begin n_fail++; $display("FAIL post_flush_ir: got %h want %h", ir_id, SUB_R3_R2_R4); end
   endtask

   task automatic test_halt();
      ir_if = HLT; flush = 1'b1;
      step();
      n_checks++; if (halted !== 1'b0)   begin n_fail++; $display("FAIL hlt_flush_halted: got %b want 0", halted); end
      n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL hlt_flush_valid: got %b want 0", valid_id); end
      flush = 1'b0;
      step();
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_halted: got %b want 1", halted); end
      n_checks++; if (ir_id !== HLT)   begin n_fail++; $display("FAIL hlt_ir: got %h want %h", ir_id, HLT); end
      ir_if = ADDI_R1_R0_M3;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL halt_bubble_valid%0d: got %b want 0", i, valid_id); end
         n_checks++; if (halted !== 1'b1)   begin n_fail++; $display("FAIL halt_sticky%0d: got %b want 1", i, halted); end
      end
   endtask

   task automatic test_reset_mid_stall();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0055;
      step();
      wb_addr = 5'd4; wb_data = 32'h0000_0066; ir_if = LW_R2_0_R1; valid_if = 1'b1;
      step();
      wb_en = 1'b0; ir_if = ADD_R3_R2_R4;
      settle();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall: got %b want 1", stall); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_values("rst_stall");
      ir_if = SW_R2_4_R1;
      step();
      n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL rf_cleared_A: got %h want %h", a, 32'h0); end
      n_checks++; if (ir_id !== SW_R2_4_R1) begin n_fail++; $display("FAIL post_rst_ir: got %h want %h", ir_id, SW_R2_4_R1); end
      ir_if = ADD_R3_R2_R4;
      step();
      n_checks++; if (b !== 32'h0) begin n_fail++; $display("FAIL rf_cleared_B: got %h want %h", b, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_decode_imm();
      test_bypass();
      test_load_use();
      test_flush();
      test_halt();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the MIPS32 five-stage pipeline: sits between fetch and execute, owns the 32×32 register file, and drives the ID/EX pipeline register (A, B, Imm, NPC_id, IR_id) consumed by the execute stage. It detects load-use hazards and stalls fetch for one cycle. It inserts bubbles on stall and on taken-branch flush, and latches a sticky halt on HLT.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- REG_N, 32, architectural register count; r0 is hardwired to zero.
- NOP_IR, 32'h0000_0000, bubble encoding (ADD r0,r0,r0).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- IR_if  in  32  instruction from fetch.
- NPC_if  in  32  next PC from fetch.
- valid_if  in  1  IR_if/NPC_if hold a real instruction.
- flush  in  1  execute-stage branch taken this cycle; kill the instruction in decode.
- wb_en  in  1  register-file write enable from writeback.
- wb_addr  in  5  write register index.
- wb_data  in  32  write data.
- A  out  32  rs operand, registered.
- B  out  32  rt operand, registered.
- Imm  out  32  sign-extended IR[15:0], registered.
- NPC_id  out  32  registered NPC_if.
- IR_id  out  32  registered instruction, or NOP_IR for a bubble.
- valid_id  out  1  ID/EX holds a real instruction.
- stall  out  1  combinational; fetch must hold IR_if/NPC_if this cycle.
- halted  out  1  sticky; an HLT has entered ID/EX.

## Operation
Instruction fields:
- opcode = IR[31:26], rs = IR[25:21], rt = IR[20:16], rd = IR[15:11].

Instruction classes:
- ALU: opcode[5]=0.
  - opcode[4]=0 is register-register: reads rs and rt, writes rd.
  - opcode[4]=1 is register-immediate: reads rs, writes rt.
  - opcode[3:0] values 0..5 select add, sub, mul, slt, or, and.
- LW 100000: reads rs, writes rt.
- SW 100001: reads rs and rt, no write.
- BEQZ 110100 and BNEQZ 110101: read rs, no write.
- HLT 111111: no reads, no write.
- All other opcodes: decode as NOP with no reads, but still pass through with valid_id=1.

Register file:
- Write on the clock edge when wb_en=1 and wb_addr≠0.
- Reads are combinational.
- Read-during-write to the same nonzero index returns wb_data (write-first bypass).
- r0 always reads 0.

Load-use hazard:
- stall=1 when all of the following hold:
  - valid_id=1 and IR_id is LW;
  - IR_id.rt≠0;
  - valid_if=1 and not halted;
  - IR_if reads a register equal to IR_id.rt.

ID/EX update priority, highest first:
1. rst_n=0: load bubble, clear the register file, clear halted.
2. flush=1: load bubble; a stall in the same cycle is ignored; stall output is forced to 0.
3. halted=1: load bubble.
4. stall=1: load bubble; fetch holds its inputs.
5. valid_if=1: load the decoded instruction, valid_id=1.
6. Otherwise: load bubble.

Bubble contents: IR_id=NOP_IR, A=B=Imm=NPC_id=0, valid_id=0.

Halt:
- halted sets on the edge that loads a valid HLT into ID/EX.
- It clears only on reset.
- A flush in the same cycle as HLT decode discards the HLT, so halted does not set.

Widths: Imm = {{16{IR[15]}}, IR[15:0]}. No other arithmetic is performed in this block.

## Timing
- Decode-to-ID/EX latency: 1 cycle.
- All outputs except stall are registered.
- stall depends combinationally on IR_if, valid_if, IR_id, valid_id, flush and halted.
- Writeback in cycle N is visible to an instruction decoded in cycle N through the bypass.
- A load-use pair costs exactly 1 bubble.
- Reset values of outputs:
  - IR_id = NOP_IR, A = B = Imm = NPC_id = 0.
  - valid_id = 0, halted = 0.
  - stall = 0, because valid_id = 0.
- Reset asserted mid-stall or mid-flush: the next edge yields the reset values; no instruction survives.

## Structure
- Shared package mips32_pkg holds:
  - opcode constants (ALU ops, LW, SW, BEQZ, BNEQZ, HLT);
  - NOP_IR;
  - field-position localparams;
  - functions: reads_rs, reads_rt, dest_reg, is_load.
- The execute stage reuses the same package.
- One sub-module: regfile.
  - Ports: two combinational read ports, one write port, synchronous active-low clear.
  - Provides the write-first bypass and the r0 hardwire.

## Test plan
- Reset then ADDI r1,r0,#-3: one cycle later Imm=32'hFFFF_FFFD, A=0, valid_id=1, IR_id matches the input instruction.
- Write r5=32'h1234 via wb_en while decoding ADD r6,r5,r5 in the same cycle: A=B=32'h1234. Write to r0: r0 still reads 0.
- LW r2,0(r1) followed by ADD r3,r2,r4:
  - stall=1 for exactly one cycle;
  - ID/EX then holds a bubble (valid_id=0, IR_id=0);
  - the ADD enters ID/EX on the following cycle.
  - With LW r0 or an unrelated rt, stall stays 0.
- flush=1 while a valid SUB is in decode and a load-use stall is pending: next cycle holds a bubble and stall=0 during the flush cycle.
- HLT decoded: halted=1 from the next cycle and all later cycles load bubbles despite valid_if=1. HLT together with flush: halted stays 0.
- Assert rst_n=0 during a stall cycle: next cycle shows the reset values of all outputs and the register file reads 0.
